// File: rtl/pipe_reg_scoreboard.sv
// pipe_reg_scoreboard: issue-stage scoreboard for the pipeline register file.
// Tracks in-flight writes per register, stalls issue on RAW hazards and on
// over-subscribed destinations, and sequences a pipeline drain.
// Optional feature macro: SB_WB_BYPASS_EN. When it is defined, a source
// hazard is suppressed if the last pending write to that source retires
// through writeback in the same cycle.
module pipe_reg_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_uses_rs,
  input  logic        issue_uses_rt,
  input  logic        issue_writes,
  input  logic [4:0]  issue_dst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dst,
  input  logic        drain_req,
  output logic        stall,
  output logic        issue_accept,
  output logic        drain_done,
  output logic [31:0] pending_mask,
  output logic [7:0]  inflight_total,
  output logic        sb_error
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  logic [CW-1:0] count_q [NUM_REGS];
  logic [CW-1:0] count_d [NUM_REGS];
  state_e        state_q, state_d;
  logic          drain_done_q, drain_done_d;
  logic [7:0]    total_q, total_d;
  logic          err_q, err_d;

  logic [CW-1:0] cnt_rs_s, cnt_rt_s, cnt_dst_s, cnt_wb_s;
  logic          rs_byp_s, rt_byp_s;
  logic          rs_hz_s, rt_hz_s, waw_full_s;
  logic          inc_s, dec_s, same_s, up_s, down_s;

  // Hazard detection against the current counts; stall and accept are combinational.
  always_comb begin
    cnt_rs_s  = count_q[issue_rs];
    cnt_rt_s  = count_q[issue_rt];
    cnt_dst_s = count_q[issue_dst];
    cnt_wb_s  = count_q[wb_dst];
`ifdef SB_WB_BYPASS_EN
    // The regfile forwards the writeback value, so the last pending write
    // retiring this cycle does not block a reader.
    rs_byp_s = wb_valid & (wb_dst == issue_rs) & (cnt_rs_s == CNT_ONE);
    rt_byp_s = wb_valid & (wb_dst == issue_rt) & (cnt_rt_s == CNT_ONE);
`else
    rs_byp_s = 1'b0;
    rt_byp_s = 1'b0;
`endif
    rs_hz_s    = issue_uses_rs & (issue_rs != 5'd0) & (cnt_rs_s != CNT_ZERO) & ~rs_byp_s;
    rt_hz_s    = issue_uses_rt & (issue_rt != 5'd0) & (cnt_rt_s != CNT_ZERO) & ~rt_byp_s;
    waw_full_s = issue_writes & (issue_dst != 5'd0) & (cnt_dst_s == CNT_MAX);
    stall        = issue_valid & (rs_hz_s | rt_hz_s | waw_full_s | (state_q != ST_IDLE));
    issue_accept = issue_valid & ~stall & ~waitrequest;
  end

  // Classify this cycle's increment/decrement; same-register inc+dec cancels out.
  always_comb begin
    inc_s  = issue_accept & issue_writes & (issue_dst != 5'd0);
    dec_s  = wb_valid & (wb_dst != 5'd0);
    same_s = inc_s & dec_s & (issue_dst == wb_dst);
    up_s   = inc_s & ~same_s & (cnt_dst_s != CNT_MAX);
    down_s = dec_s & ~same_s & (cnt_wb_s != CNT_ZERO);
    err_d  = err_q | (dec_s & ~same_s & (cnt_wb_s == CNT_ZERO));
  end

  // Next-state per-register counts; register 0 is pinned to zero.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == 0) begin
        count_d[i] = CNT_ZERO;
      end else if (up_s && (issue_dst == 5'(i))) begin
        count_d[i] = count_q[i] + CNT_ONE;
      end else if (down_s && (wb_dst == 5'(i))) begin
        count_d[i] = count_q[i] - CNT_ONE;
      end else begin
        count_d[i] = count_q[i];
      end
    end
  end

  // Running total follows the same +1/-1 events and saturates instead of wrapping.
  always_comb begin
    total_d = total_q;
    case ({up_s, down_s})
      2'b10: begin
        if (total_q != 8'hFF) total_d = total_q + 8'd1;
        else                  total_d = total_q;
      end
      2'b01: begin
        if (total_q != 8'h00) total_d = total_q - 8'd1;
        else                  total_d = total_q;
      end
      default: total_d = total_q;
    endcase
  end

  // Drain sequencer next state; DONE is entered once the pipeline will be empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (drain_req) state_d = ST_DRAIN;
        else           state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!drain_req)             state_d = ST_IDLE;
        else if (total_d == 8'h00)  state_d = ST_DONE;
        else                        state_d = ST_DRAIN;
      end
      ST_DONE: begin
        if (!drain_req) state_d = ST_IDLE;
        else            state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    drain_done_d = (state_d == ST_DONE);
  end

  // State registers; everything holds while memory asserts waitrequest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) count_q[i] <= CNT_ZERO;
      state_q      <= ST_IDLE;
      drain_done_q <= 1'b0;
      total_q      <= 8'h00;
      err_q        <= 1'b0;
    end else if (!waitrequest) begin
      for (int i = 0; i < NUM_REGS; i++) count_q[i] <= count_d[i];
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      total_q      <= total_d;
      err_q        <= err_d;
    end
  end

  // Pending bit per register, derived from the registered counts.
  always_comb begin
    pending_mask = 32'h0000_0000;
    for (int i = 1; i < NUM_REGS; i++) begin
      pending_mask[i] = (count_q[i] != CNT_ZERO);
    end
  end

  assign drain_done     = drain_done_q;
  assign inflight_total = total_q;
  assign sb_error       = err_q;

endmodule

// File: doc/pipe_reg_scoreboard.md
Name: pipe_reg_scoreboard

Overview:
- Issue-stage scoreboard guarding the pipeline register file.
- Keeps a per-register count of in-flight writes, i.e. instructions issued whose writeback has not yet happened.
- Stalls issue when a source register, or an over-subscribed destination register, is pending.
- Provides a drain sequencer that empties the pipeline (count 0 on every register) before syscall/halt handling.

Parameters:
- MAX_INFLIGHT, 3, maximum outstanding writes tracked per register; counter width CW = $clog2(MAX_INFLIGHT+1).
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- waitrequest  input  1  memory stall; when 1, all state is frozen and no issue is accepted.
- issue_valid  input  1  instruction at IF/ID is presented for issue.
- issue_rs  input  5  source register 1 (instr[25:21]).
- issue_rt  input  5  source register 2 (instr[20:16]).
- issue_uses_rs  input  1  instruction reads rs.
- issue_uses_rt  input  1  instruction reads rt.
- issue_writes  input  1  instruction will write a register.
- issue_dst  input  5  resolved destination (rt, rd or 31 for link instructions).
- wb_valid  input  1  MEM/WB performs a register write this cycle.
- wb_dst  input  5  register written at writeback.
- drain_req  input  1  request to empty the pipeline.
- stall  output  1  issue blocked this cycle (combinational).
- issue_accept  output  1  issue_valid & !stall & !waitrequest (combinational).
- drain_done  output  1  pipeline empty while draining (registered).
- pending_mask  output  32  bit i = (count[i] != 0); bit 0 is always 0.
- inflight_total  output  8  registered sum of all counts.
- sb_error  output  1  sticky error flag.

Behaviour:
- Reset: all counts 0, FSM IDLE, drain_done 0, pending_mask 0, inflight_total 0, sb_error 0. Reset applied mid-drain or mid-operation discards all pending state immediately.
- Hazard terms (any true means hazard):
  - rs hazard: issue_uses_rs & issue_rs!=0 & count[rs]!=0.
  - rt hazard: the same test on rt.
  - waw_full: issue_writes & issue_dst!=0 & count[dst]==MAX_INFLIGHT.
- stall = issue_valid & (rs hazard | rt hazard | waw_full | state!=IDLE). Writes to register 0 are never tracked.
- Counter update per clock edge, only when waitrequest==0:
  - inc = issue_accept & issue_writes & dst!=0.
  - dec = wb_valid & wb_dst!=0.
  - inc and dec on the same register in the same cycle: count unchanged.
  - dec on a register whose count is 0: count stays 0, sb_error set.
  - inc cannot occur at MAX_INFLIGHT because stall prevents it.
- inflight_total tracks the same +1/-1 updates in the same cycle; it never wraps.
- When waitrequest==1: counters, FSM, drain_done and inflight_total hold; issue_accept=0; stall is still computed.
- Drain FSM (advances only when waitrequest==0):
  - IDLE -> DRAIN when drain_req=1.
  - DRAIN -> DONE on the edge where the next inflight_total is 0.
  - DRAIN -> IDLE if drain_req drops.
  - DONE: drain_done=1; -> IDLE when drain_req=0, with drain_done cleared on that edge.
  - DRAIN and DONE block all issue; writebacks are still counted.
- drain_req asserted when already empty: IDLE -> DRAIN on the first edge, then DONE on the next edge (2-cycle latency).
- sb_error clears only on reset.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: a source hazard is suppressed when wb_valid & wb_dst==src & count[src]==1 in the same cycle, because the regfile write/read path forwards that value. The WAW check is unchanged.
- Undefined: any nonzero count on a source register stalls, including during same-cycle writeback.

Test Plan:
- Reset with counts nonzero -> all outputs 0 immediately, before the next clk edge.
- Issue writes dst=5 (accepted), then issue uses_rs rs=5 -> stall=1 until wb_valid wb_dst=5. Without the macro, stall drops the cycle after WB; with SB_WB_BYPASS_EN, stall=0 in the WB cycle itself.
- Three accepted writes to dst=8 (MAX=3) -> pending_mask[8]=1, inflight_total=3; a fourth write to 8 -> stall=1. A simultaneous issue to 8 with wb 8 at count 2 -> count stays 2.
- Issue with dst=0 and wb_dst=0 -> counts unchanged, pending_mask=0, sb_error=0. wb_dst=9 with count 0 -> sb_error=1, sticky.
- inflight_total=2, drain_req=1 -> stall=1 for all issue; two writebacks -> drain_done=1 one edge after the last; drop drain_req -> IDLE, drain_done=0.
- waitrequest=1 for 4 cycles while issue_valid, wb_valid and drain_req are active -> counts, inflight_total and FSM unchanged; issue_accept=0 throughout.
